// File: rtl/nand_logic_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and per-opcode step helpers for the NAND sequencer.
package nand_logic_sequencer_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned STEP_W = 2;

    localparam logic [OP_W-1:0] OP_NAND = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index of the final NAND step for one result bit (steps per bit minus one).
    function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
        case (op)
            OP_NAND: last_step = 2'd0;
            OP_AND:  last_step = 2'd1;
            OP_OR:   last_step = 2'd2;
            OP_XOR:  last_step = 2'd3;
            OP_NOTA: last_step = 2'd0;
            default: last_step = 2'd0;
        endcase
    endfunction

    // Opcodes 5..7 have no defined function.
    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        op_reserved = (op > OP_NOTA);
    endfunction

endpackage

// File: rtl/nand_logic_sequencer_if.sv
// Request/response handshake bundle between decode, the sequencer and the result bus.
interface nand_logic_sequencer_if #(
    parameter int unsigned WIDTH = 8
) ();
    import nand_logic_sequencer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  q;
    logic              err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, q, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, q, err
    );
endinterface

// File: rtl/nand_logic_sequencer_nand00.sv
// The single two-input NAND cell shared by every operation.
module nand00 (
    input  logic a,
    input  logic b,
    output logic q
);
    assign q = ~(a & b);
endmodule

// File: rtl/nand_logic_sequencer.sv
// Bit-serial logic unit: schedules one NAND evaluation per cycle on a single shared gate.
module nand_logic_sequencer
    import nand_logic_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    nand_logic_sequencer_if.slave   bus,
    output logic                    busy
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e              state, state_n;
    logic [WIDTH-1:0]    a_r, a_n, b_r, b_n, result, result_n;
    logic [OP_W-1:0]     op_r, op_n;
    logic [IDX_W-1:0]    bit_idx, bit_n;
    logic [STEP_W-1:0]   step, step_n;
    logic                t1, t1_n, t2, t2_n, t3, t3_n;
    logic                err_r, err_n;
    logic                in_ready_r, out_valid_r, busy_r;
    logic                ai, bi, g_a, g_b, g_q;

    assign ai = a_r[bit_idx];
    assign bi = b_r[bit_idx];

    nand00 u_nand (
        .a (g_a),
        .b (g_b),
        .q (g_q)
    );

    // Step mux: selects the shared gate's operands for the current op/step.
    always_comb begin
        g_a = 1'b0;
        g_b = 1'b0;
        if (state == EXEC) begin
            case (op_r)
                OP_NAND: begin g_a = ai; g_b = bi; end
                OP_AND: begin
                    if (step == 2'd0) begin g_a = ai; g_b = bi; end
                    else              begin g_a = t1; g_b = t1; end
                end
                OP_OR: begin
                    case (step)
                        2'd0:    begin g_a = ai; g_b = ai; end
                        2'd1:    begin g_a = bi; g_b = bi; end
                        default: begin g_a = t1; g_b = t2; end
                    endcase
                end
                OP_XOR: begin
                    case (step)
                        2'd0:    begin g_a = ai; g_b = bi; end
                        2'd1:    begin g_a = ai; g_b = t1; end
                        2'd2:    begin g_a = bi; g_b = t1; end
                        default: begin g_a = t2; g_b = t3; end
                    endcase
                end
                OP_NOTA: begin g_a = ai; g_b = ai; end
                default: begin g_a = 1'b0; g_b = 1'b0; end
            endcase
        end
    end

    // Next-state and datapath update: accept, per-step temp/result writes, output handshake.
    always_comb begin
        state_n  = state;
        a_n      = a_r;
        b_n      = b_r;
        op_n     = op_r;
        bit_n    = bit_idx;
        step_n   = step;
        t1_n     = t1;
        t2_n     = t2;
        t3_n     = t3;
        result_n = result;
        err_n    = err_r;
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    result_n = '0;
                    if (op_reserved(bus.op)) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        a_n     = bus.a;
                        b_n     = bus.b;
                        op_n    = bus.op;
                        err_n   = 1'b0;
                        bit_n   = '0;
                        step_n  = '0;
                        t1_n    = 1'b0;
                        t2_n    = 1'b0;
                        t3_n    = 1'b0;
                        state_n = EXEC;
                    end
                end
            end
            EXEC: begin
                if (step == last_step(op_r)) begin
                    result_n[bit_idx] = g_q;
                    step_n            = '0;
                    if (bit_idx == IDX_W'(WIDTH - 1)) begin
                        state_n = DONE;
                    end else begin
                        bit_n = IDX_W'(bit_idx + 1'b1);
                    end
                end else begin
                    step_n = STEP_W'(step + 1'b1);
                    case (step)
                        2'd0:    t1_n = g_q;
                        2'd1:    t2_n = g_q;
                        default: t3_n = g_q;
                    endcase
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; handshake outputs track next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= '0;
            bit_idx     <= '0;
            step        <= '0;
            t1          <= 1'b0;
            t2          <= 1'b0;
            t3          <= 1'b0;
            result      <= '0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state       <= state_n;
            a_r         <= a_n;
            b_r         <= b_n;
            op_r        <= op_n;
            bit_idx     <= bit_n;
            step        <= step_n;
            t1          <= t1_n;
            t2          <= t2_n;
            t3          <= t3_n;
            result      <= result_n;
            err_r       <= err_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
            busy_r      <= (state_n != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.q         = result;
    assign bus.err       = err_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_nand_logic_sequencer.sv
// Directed self-checking bench for nand_logic_sequencer (WIDTH=8).
module tb_nand_logic_sequencer;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    nand_logic_sequencer_if #(.WIDTH(W)) bus ();

    nand_logic_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for out_valid (bounded), optionally consume the result.
    // lat = rising edges after the accept edge until out_valid is seen high (-1 on timeout).
    task automatic run_op(input logic [2:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input bit consume, output int lat, output logic [W-1:0] q_v,
                          output logic err_v, output bit acc_ok);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        acc_ok = (bus.in_ready === 1'b1);
        bus.in_valid = 1'b1;
        bus.op       = op_v;
        bus.a        = a_v;
        bus.b        = b_v;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a_v;
        bus.b        = ~b_v;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
        if (bus.out_valid !== 1'b1) lat = -1;
        q_v   = bus.q;
        err_v = bus.err;
        if (consume) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus.q); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_ops();
        logic [2:0]   ops  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        logic [W-1:0] expq [6] = '{8'h3F, 8'hC0, 8'hFC, 8'h3C, 8'h0F, 8'h00};
        logic         experr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int           explat [6] = '{8, 16, 24, 32, 8, 0};
        int           lat;
        logic [W-1:0] qv;
        logic         ev;
        bit           ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], 8'hF0, 8'hCC, 1'b0, lat, qv, ev, ok);
            checks++; if (!ok) begin errors++; $display("FAIL op%0d_accept in_ready not seen", ops[i]); end
            checks++; if (lat != explat[i]) begin errors++; $display("FAIL op%0d_latency got=%0d exp=%0d", ops[i], lat, explat[i]); end
            checks++; if (qv !== expq[i]) begin errors++; $display("FAIL op%0d_q got=%h exp=%h", ops[i], qv, expq[i]); end
            checks++; if (ev !== experr[i]) begin errors++; $display("FAIL op%0d_err got=%b exp=%b", ops[i], ev, experr[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL op%0d_busy_done got=%b exp=1", ops[i], busy); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL op%0d_handshake in_ready=%b out_valid=%b exp 1/0", ops[i], bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_done_hold();
        int           lat;
        logic [W-1:0] qv;
        logic         ev;
        bit           ok;
        run_op(3'd3, 8'hF0, 8'hCC, 1'b0, lat, qv, ev, ok);
        checks++; if (qv !== 8'h3C || lat != 32) begin errors++; $display("FAIL hold_xor q=%h lat=%0d exp 3c/32", qv, lat); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.op       = 3'd0;
                bus.a        = 8'hFF;
                bus.b        = 8'hFF;
            end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.q !== 8'h3C || bus.in_ready !== 1'b0 || bus.err !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d out_valid=%b q=%h in_ready=%b err=%b exp 1/3c/0/0",
                                   i, bus.out_valid, bus.q, bus.in_ready, bus.err);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 8'h3C) begin
            errors++; $display("FAIL hold_release in_ready=%b out_valid=%b q=%h exp 1/0/3c", bus.in_ready, bus.out_valid, bus.q);
        end
    endtask

    task automatic test_reset_mid();
        int           lat;
        logic [W-1:0] qv;
        logic         ev;
        bit           ok;
        bus.in_valid = 1'b1;
        bus.op       = 3'd3;
        bus.a        = 8'hF0;
        bus.b        = 8'hCC;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.q !== 8'h00 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_state out_valid=%b q=%h busy=%b in_ready=%b exp 0/00/0/0",
                               bus.out_valid, bus.q, busy, bus.in_ready);
        end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release in_ready=%b exp=1", bus.in_ready); end
        run_op(3'd0, 8'hFF, 8'hFF, 1'b1, lat, qv, ev, ok);
        checks++; if (qv !== 8'h00 || lat != 8 || ev !== 1'b0) begin
            errors++; $display("FAIL midrst_nand q=%h lat=%0d err=%b exp 00/8/0", qv, lat, ev);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops  [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
        logic [W-1:0] av   [4] = '{8'hA5, 8'h0F, 8'h96, 8'hFF};
        logic [W-1:0] bv   [4] = '{8'h3C, 8'h50, 8'h00, 8'h81};
        logic [W-1:0] expq [4] = '{8'h24, 8'h5F, 8'h69, 8'h7E};
        int           gap  [3] = '{18, 26, 10};
        int           acc  [4];
        int           n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op = ops[0]; bus.a = av[0]; bus.b = bv[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
            tick();
            acc[i] = cyc;
            if (i < 3) begin
                bus.op = ops[i+1]; bus.a = av[i+1]; bus.b = bv[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 200) begin tick(); n++; end
            checks++; if (bus.out_valid !== 1'b1 || bus.q !== expq[i]) begin
                errors++; $display("FAIL b2b%0d_q out_valid=%b q=%h exp 1/%h", i, bus.out_valid, bus.q, expq[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (acc[i+1] - acc[i] != gap[i]) begin
                errors++; $display("FAIL b2b%0d_spacing got=%0d exp=%0d", i, acc[i+1] - acc[i], gap[i]);
            end
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_ops();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_logic_sequencer.md
Name: nand_logic_sequencer

Overview:
Bit-serial logic unit that computes a 2-operand bitwise function over a WIDTH-bit word using exactly one shared nand00 gate instance. It issues one NAND evaluation per cycle and chains the evaluations through internal temporaries to build AND/OR/XOR/NOT. It sits between the decode stage (valid/ready request) and the result bus (valid/ready response). It is the scheduler that owns the single NAND resource.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready at rising edge
op  input  3  operation code, sampled on accept
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready at rising edge
q  output  WIDTH  result, registered
err  output  1  reserved opcode flag, qualified by out_valid
busy  output  1  high in EXEC or DONE

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high. All state changes occur on the rising edge of clk.
- Opcodes and steps per bit (S):
  - 0 NAND: S=1.
  - 1 AND: S=2, nand(a,b) then nand(t,t).
  - 2 OR: S=3, nand(a,a), nand(b,b), nand(t1,t2).
  - 3 XOR: S=4, t=nand(a,b), u=nand(a,t), v=nand(b,t), nand(u,v).
  - 4 NOTA: S=1, nand(a,a).
  - 5-7: reserved.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1 when rst is low.
  - On accept with a valid op: latch a, b and op; clear result register, bit_idx=0, step=0; go to EXEC.
  - On accept with a reserved op: q=0, err=1; go directly to DONE.
- EXEC:
  - in_ready=0.
  - Each cycle, drive the shared gate inputs from the step mux; the gate output is written into temp t1/t2/t3 per the step table.
  - On the final step, the gate output is written to result[bit_idx]. Then step returns to 0 and bit_idx increments.
  - Bits are processed LSB first.
  - After the final step of bit WIDTH-1, go to DONE with err=0.
- DONE:
  - out_valid=1. q and err are held stable.
  - On out_ready: go to IDLE, out_valid=0. q keeps its last value until the next accept.
- Latency and throughput:
  - out_valid rises exactly WIDTH*S cycles after the accept edge, or 1 cycle for a reserved op.
  - A new request cannot be accepted in the same cycle as the output handshake, so the minimum period is WIDTH*S+2 cycles.
- in_valid outside IDLE is ignored. Operands may change freely after accept.
- out_ready held low keeps the block in DONE indefinitely with outputs stable.
- X on a or b propagates through the gate. No X may appear on the control outputs.
- Reset, including mid-EXEC or in DONE: next state IDLE, out_valid=0, q=0, err=0, busy=0, bit_idx=0, step=0, temporaries cleared. in_ready=0 while rst is high and 1 on the first cycle after release.

Decomposition:
- Shared header logic_ops.vh holds:
  - opcode localparams OP_NAND=0, OP_AND=1, OP_OR=2, OP_XOR=3, OP_NOTA=4;
  - state encodings IDLE/EXEC/DONE;
  - the per-opcode step-count function.
- Sub-module: the existing nand00 (ports a, b, q), instantiated exactly once. No other logic gate computes the result bits.
- Step-to-operand mux and FSM stay in this module.

Test Plan:
- WIDTH=8, a=8'hF0, b=8'hCC, op=0 -> q=8'h3F, err=0, out_valid exactly 8 cycles after accept.
- Same operands, op=1/2/3/4 -> q=8'hC0 at 16 cycles / 8'hFC at 24 / 8'h3C at 32 / 8'h0F at 8.
- op=6 accepted -> out_valid next cycle, q=8'h00, err=1.
- XOR request, then out_ready held low 10 cycles -> out_valid and q=8'h3C stable; in_ready=0; a second in_valid is ignored. Raising out_ready gives in_ready=1 on the following cycle.
- rst pulsed at cycle 5 of an XOR op -> next cycle out_valid=0, q=0, busy=0. A fresh NAND of 8'hFF,8'hFF then returns 8'h00 after 8 cycles.
- Back-to-back requests with out_ready=1 tied high -> each result is correct, and accepts are spaced WIDTH*S+2 cycles apart.
